// File: rtl/armleosoc_axi_read_router_ot.sv
// 1-to-N AXI4 read router with multiple outstanding bursts to a single client.
// Unmapped addresses are answered by an internal DECERR responder.
module armleosoc_axi_read_router_ot #(
  parameter int ADDR_WIDTH            = 34,
  parameter int ID_WIDTH              = 4,
  parameter int DATA_WIDTH            = 32,
  parameter int OPT_NUMBER_OF_CLIENTS = 2,
  parameter int MAX_OUTSTANDING       = 4,
  parameter int REGION_COUNT          = OPT_NUMBER_OF_CLIENTS,
  parameter logic [REGION_COUNT*((OPT_NUMBER_OF_CLIENTS > 1) ?
                   $clog2(OPT_NUMBER_OF_CLIENTS) : 1)-1:0] REGION_CLIENT_NUM = '0,
  parameter logic [REGION_COUNT*ADDR_WIDTH-1:0] REGION_BASE_ADDRS        = '0,
  parameter logic [REGION_COUNT*ADDR_WIDTH-1:0] REGION_END_ADDRS         = '0,
  parameter logic [REGION_COUNT*ADDR_WIDTH-1:0] REGION_CLIENT_BASE_ADDRS = '0
) (
  input  logic                                      clk,
  input  logic                                      rst,

  input  logic                                      upstream_axi_arvalid,
  output logic                                      upstream_axi_arready,
  input  logic [ADDR_WIDTH-1:0]                     upstream_axi_araddr,
  input  logic [7:0]                                upstream_axi_arlen,
  input  logic [2:0]                                upstream_axi_arsize,
  input  logic [1:0]                                upstream_axi_arburst,
  input  logic [ID_WIDTH-1:0]                       upstream_axi_arid,
  input  logic                                      upstream_axi_arlock,
  input  logic [2:0]                                upstream_axi_arprot,

  output logic                                      upstream_axi_rvalid,
  input  logic                                      upstream_axi_rready,
  output logic [1:0]                                upstream_axi_rresp,
  output logic                                      upstream_axi_rlast,
  output logic [DATA_WIDTH-1:0]                     upstream_axi_rdata,
  output logic [ID_WIDTH-1:0]                       upstream_axi_rid,

  output logic [OPT_NUMBER_OF_CLIENTS-1:0]          downstream_axi_arvalid,
  input  logic [OPT_NUMBER_OF_CLIENTS-1:0]          downstream_axi_arready,
  output logic [ADDR_WIDTH-1:0]                     downstream_axi_araddr,
  output logic [7:0]                                downstream_axi_arlen,
  output logic [2:0]                                downstream_axi_arsize,
  output logic [1:0]                                downstream_axi_arburst,
  output logic [ID_WIDTH-1:0]                       downstream_axi_arid,
  output logic                                      downstream_axi_arlock,
  output logic [2:0]                                downstream_axi_arprot,

  input  logic [OPT_NUMBER_OF_CLIENTS-1:0]          downstream_axi_rvalid,
  output logic [OPT_NUMBER_OF_CLIENTS-1:0]          downstream_axi_rready,
  input  logic [OPT_NUMBER_OF_CLIENTS*2-1:0]        downstream_axi_rresp,
  input  logic [OPT_NUMBER_OF_CLIENTS-1:0]          downstream_axi_rlast,
  input  logic [OPT_NUMBER_OF_CLIENTS*DATA_WIDTH-1:0] downstream_axi_rdata,
  input  logic [OPT_NUMBER_OF_CLIENTS*ID_WIDTH-1:0] downstream_axi_rid
);

  localparam int CW = (OPT_NUMBER_OF_CLIENTS > 1) ? $clog2(OPT_NUMBER_OF_CLIENTS) : 1;
  localparam int OW = $clog2(MAX_OUTSTANDING + 1);

  typedef enum logic [0:0] {StRoute, StDecerr} state_e;

  state_e                state_q, state_d;
  logic                  ar_full_q, ar_full_d;
  logic [CW-1:0]         cur_client_q, cur_client_d;
  logic [OW-1:0]         count_q, count_d;
  logic [ID_WIDTH-1:0]   dec_id_q, dec_id_d;
  logic [7:0]            dec_len_q, dec_len_d;
  logic [7:0]            beat_q, beat_d;

  // Holding register fields, loaded on the upstream AR handshake
  logic                  hit_q;
  logic [CW-1:0]         cl_q;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [7:0]            len_q;
  logic [2:0]            size_q;
  logic [1:0]            burst_q;
  logic [ID_WIDTH-1:0]   id_q;
  logic                  lock_q;
  logic [2:0]            prot_q;

  logic                  dec_hit;
  logic [CW-1:0]         dec_cl;
  logic [ADDR_WIDTH-1:0] dec_addr;
  logic                  ar_hs;
  logic                  issue_ok;
  logic                  ds_ar_hs;
  logic                  r_last_hs;

  assign ar_hs = upstream_axi_arvalid && upstream_axi_arready;

  // Region decode; iterating downwards lets the lowest-index match win
  always_comb begin
    dec_hit  = 1'b0;
    dec_cl   = '0;
    dec_addr = '0;
    for (int r = REGION_COUNT - 1; r >= 0; r--) begin
      if (upstream_axi_araddr >= REGION_BASE_ADDRS[r*ADDR_WIDTH +: ADDR_WIDTH] &&
          upstream_axi_araddr <  REGION_END_ADDRS[r*ADDR_WIDTH +: ADDR_WIDTH]) begin
        dec_hit  = 1'b1;
        dec_cl   = REGION_CLIENT_NUM[r*CW +: CW];
        dec_addr = upstream_axi_araddr - REGION_CLIENT_BASE_ADDRS[r*ADDR_WIDTH +: ADDR_WIDTH];
      end
    end
  end

  // Same-client bursts may pile up to the limit; a client switch waits for an idle R path
  assign issue_ok = !rst && (state_q == StRoute) && ar_full_q && hit_q &&
                    ((count_q == '0) ||
                     ((cl_q == cur_client_q) && (count_q < OW'(MAX_OUTSTANDING))));

  // AR issue and R-path muxing
  always_comb begin
    upstream_axi_arready   = !ar_full_q && !rst;
    downstream_axi_arvalid = '0;
    downstream_axi_rready  = '0;
    ds_ar_hs               = 1'b0;
    r_last_hs              = 1'b0;
    upstream_axi_rvalid    = 1'b0;
    upstream_axi_rresp     = 2'b00;
    upstream_axi_rlast     = 1'b0;
    upstream_axi_rdata     = '0;
    upstream_axi_rid       = '0;
    for (int i = 0; i < OPT_NUMBER_OF_CLIENTS; i++) begin
      if (issue_ok && (cl_q == CW'(i))) begin
        downstream_axi_arvalid[i] = 1'b1;
        ds_ar_hs                  = downstream_axi_arready[i];
      end
    end
    if (!rst) begin
      if (state_q == StDecerr) begin
        upstream_axi_rvalid = 1'b1;
        upstream_axi_rresp  = 2'b11;
        upstream_axi_rid    = dec_id_q;
        upstream_axi_rlast  = (beat_q == dec_len_q);
      end else if (count_q != '0) begin
        for (int i = 0; i < OPT_NUMBER_OF_CLIENTS; i++) begin
          if (cur_client_q == CW'(i)) begin
            upstream_axi_rvalid      = downstream_axi_rvalid[i];
            upstream_axi_rresp       = downstream_axi_rresp[i*2 +: 2];
            upstream_axi_rlast       = downstream_axi_rlast[i];
            upstream_axi_rdata       = downstream_axi_rdata[i*DATA_WIDTH +: DATA_WIDTH];
            upstream_axi_rid         = downstream_axi_rid[i*ID_WIDTH +: ID_WIDTH];
            downstream_axi_rready[i] = upstream_axi_rready;
            r_last_hs = downstream_axi_rvalid[i] && upstream_axi_rready &&
                        downstream_axi_rlast[i];
          end
        end
      end
    end
  end

  assign downstream_axi_araddr  = addr_q;
  assign downstream_axi_arlen   = len_q;
  assign downstream_axi_arsize  = size_q;
  assign downstream_axi_arburst = burst_q;
  assign downstream_axi_arid    = id_q;
  assign downstream_axi_arlock  = lock_q;
  assign downstream_axi_arprot  = prot_q;

  // Next-state: holding register, in-flight tracking and DECERR responder
  always_comb begin
    state_d      = state_q;
    ar_full_d    = ar_full_q;
    cur_client_d = cur_client_q;
    count_d      = count_q;
    dec_id_d     = dec_id_q;
    dec_len_d    = dec_len_q;
    beat_d       = beat_q;
    if (ar_hs) begin
      ar_full_d = 1'b1;
    end
    unique case (state_q)
      StRoute: begin
        if (ds_ar_hs) begin
          ar_full_d    = 1'b0;
          cur_client_d = cl_q;
        end else if (ar_full_q && !hit_q && (count_q == '0)) begin
          state_d   = StDecerr;
          ar_full_d = 1'b0;
          dec_id_d  = id_q;
          dec_len_d = len_q;
          beat_d    = '0;
        end
        // Issue and retire in the same cycle cancel out
        if (ds_ar_hs && !r_last_hs) begin
          count_d = count_q + OW'(1);
        end else if (!ds_ar_hs && r_last_hs) begin
          count_d = count_q - OW'(1);
        end
      end
      StDecerr: begin
        if (upstream_axi_rready) begin
          if (beat_q == dec_len_q) begin
            state_d = StRoute;
          end else begin
            beat_d = beat_q + 8'd1;
          end
        end
      end
      default: state_d = StRoute;
    endcase
  end

  // State registers with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= StRoute;
      ar_full_q    <= 1'b0;
      cur_client_q <= '0;
      count_q      <= '0;
      dec_id_q     <= '0;
      dec_len_q    <= '0;
      beat_q       <= '0;
    end else begin
      state_q      <= state_d;
      ar_full_q    <= ar_full_d;
      cur_client_q <= cur_client_d;
      count_q      <= count_d;
      dec_id_q     <= dec_id_d;
      dec_len_q    <= dec_len_d;
      beat_q       <= beat_d;
    end
  end

  // AR holding register payload, decoded at acceptance
  always_ff @(posedge clk) begin
    if (rst) begin
      hit_q   <= 1'b0;
      cl_q    <= '0;
      addr_q  <= '0;
      len_q   <= '0;
      size_q  <= '0;
      burst_q <= '0;
      id_q    <= '0;
      lock_q  <= 1'b0;
      prot_q  <= '0;
    end else if (ar_hs) begin
      hit_q   <= dec_hit;
      cl_q    <= dec_cl;
      addr_q  <= dec_addr;
      len_q   <= upstream_axi_arlen;
      size_q  <= upstream_axi_arsize;
      burst_q <= upstream_axi_arburst;
      id_q    <= upstream_axi_arid;
      lock_q  <= upstream_axi_arlock;
      prot_q  <= upstream_axi_arprot;
    end
  end

endmodule

// File: tb/tb_armleosoc_axi_read_router_ot.sv
// Scoreboard bench for armleosoc_axi_read_router_ot: two clients, two outstanding bursts.
module tb_armleosoc_axi_read_router_ot;

  localparam int AW = 34;
  localparam int IW = 4;
  localparam int DW = 32;
  localparam int N  = 2;
  localparam int MO = 2;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic            up_arvalid, up_arready, up_arlock;
  logic [AW-1:0]   up_araddr;
  logic [7:0]      up_arlen;
  logic [2:0]      up_arsize, up_arprot;
  logic [1:0]      up_arburst;
  logic [IW-1:0]   up_arid;
  logic            up_rvalid, up_rready, up_rlast;
  logic [1:0]      up_rresp;
  logic [DW-1:0]   up_rdata;
  logic [IW-1:0]   up_rid;
  logic [N-1:0]    ds_arvalid, ds_arready;
  logic [AW-1:0]   ds_araddr;
  logic [7:0]      ds_arlen;
  logic [2:0]      ds_arsize, ds_arprot;
  logic [1:0]      ds_arburst;
  logic [IW-1:0]   ds_arid;
  logic            ds_arlock;
  logic [N-1:0]    ds_rvalid, ds_rready, ds_rlast;
  logic [N*2-1:0]  ds_rresp;
  logic [N*DW-1:0] ds_rdata;
  logic [N*IW-1:0] ds_rid;

  armleosoc_axi_read_router_ot #(
    .ADDR_WIDTH(AW), .ID_WIDTH(IW), .DATA_WIDTH(DW), .OPT_NUMBER_OF_CLIENTS(N),
    .MAX_OUTSTANDING(MO), .REGION_COUNT(2),
    .REGION_CLIENT_NUM(2'b10),
    .REGION_BASE_ADDRS({34'h1000, 34'h0000}),
    .REGION_END_ADDRS({34'h2000, 34'h1000}),
    .REGION_CLIENT_BASE_ADDRS({34'h1000, 34'h0000})
  ) dut (
    .clk(clk), .rst(rst),
    .upstream_axi_arvalid(up_arvalid), .upstream_axi_arready(up_arready),
    .upstream_axi_araddr(up_araddr), .upstream_axi_arlen(up_arlen),
    .upstream_axi_arsize(up_arsize), .upstream_axi_arburst(up_arburst),
    .upstream_axi_arid(up_arid), .upstream_axi_arlock(up_arlock),
    .upstream_axi_arprot(up_arprot),
    .upstream_axi_rvalid(up_rvalid), .upstream_axi_rready(up_rready),
    .upstream_axi_rresp(up_rresp), .upstream_axi_rlast(up_rlast),
    .upstream_axi_rdata(up_rdata), .upstream_axi_rid(up_rid),
    .downstream_axi_arvalid(ds_arvalid), .downstream_axi_arready(ds_arready),
    .downstream_axi_araddr(ds_araddr), .downstream_axi_arlen(ds_arlen),
    .downstream_axi_arsize(ds_arsize), .downstream_axi_arburst(ds_arburst),
    .downstream_axi_arid(ds_arid), .downstream_axi_arlock(ds_arlock),
    .downstream_axi_arprot(ds_arprot),
    .downstream_axi_rvalid(ds_rvalid), .downstream_axi_rready(ds_rready),
    .downstream_axi_rresp(ds_rresp), .downstream_axi_rlast(ds_rlast),
    .downstream_axi_rdata(ds_rdata), .downstream_axi_rid(ds_rid)
  );

  typedef struct {
    int            client;
    logic [AW-1:0] addr;
    logic [7:0]    len;
    logic [IW-1:0] id;
    int            need;  // R beats that must have completed before this AR may issue
  } exp_ar_t;

  typedef struct {
    logic [1:0]    resp;
    logic [IW-1:0] id;
    logic [DW-1:0] data;
    logic          last;
  } exp_r_t;

  typedef struct {
    int            client;
    logic [IW-1:0] id;
    logic [7:0]    len;
  } burst_t;

  exp_ar_t exp_ar[$];
  exp_r_t  exp_r[$];
  burst_t  pend[$];
  int      checks = 0;
  int      errors = 0;
  int      r_pops = 0;
  int      beat = 0;
  logic [N-1:0] r_en;
  logic [N-1:0] ar_en;

  assign ds_arready = ar_en;

  function automatic logic [DW-1:0] beat_data(input int client, input int b);
    return {8'hD0, client[7:0], 8'h5A, b[7:0]};
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_route(input int client, input logic [AW-1:0] addr,
                              input logic [7:0] len, input logic [IW-1:0] id, input int need);
    exp_ar_t a;
    exp_r_t  r;
    a.client = client; a.addr = addr; a.len = len; a.id = id; a.need = need;
    exp_ar.push_back(a);
    for (int b = 0; b <= int'(len); b++) begin
      r.resp = 2'b00; r.id = id; r.data = beat_data(client, b); r.last = (b == int'(len));
      exp_r.push_back(r);
    end
  endtask

  task automatic expect_decerr(input logic [7:0] len, input logic [IW-1:0] id);
    exp_r_t r;
    for (int b = 0; b <= int'(len); b++) begin
      r.resp = 2'b11; r.id = id; r.data = '0; r.last = (b == int'(len));
      exp_r.push_back(r);
    end
  endtask

  task automatic send_ar(input logic [AW-1:0] addr, input logic [7:0] len,
                         input logic [IW-1:0] id);
    int n;
    n = 0;
    up_araddr = addr; up_arlen = len; up_arid = id;
    up_arsize = 3'd2; up_arburst = 2'b01; up_arlock = 1'b0; up_arprot = 3'd0;
    up_arvalid = 1'b1;
    do begin
      @(negedge clk);
      n++;
    end while (!up_arready && n < 50);
    checks++;
    if (!up_arready) begin
      errors++;
      $display("FAIL send_ar %0h: arready got 0 expected 1", addr);
    end
    step();
    up_arvalid = 1'b0;
  endtask

  task automatic drain(input string name);
    int n;
    n = 0;
    while ((exp_ar.size() != 0 || exp_r.size() != 0 || pend.size() != 0) && n < 200) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (exp_ar.size() != 0 || exp_r.size() != 0 || pend.size() != 0) begin
      errors++;
      $display("FAIL drain %s: left ar=%0d r=%0d inflight=%0d expected 0", name,
               exp_ar.size(), exp_r.size(), pend.size());
    end
  endtask

  // Downstream client stub: accepts ARs, returns bursts in order when enabled
  initial begin : client_model
    logic          r_hs, a_hs, rst_s;
    int            a_cl, c;
    logic [7:0]    a_len;
    logic [IW-1:0] a_id;
    burst_t        nb;
    ds_rvalid = '0; ds_rresp = '0; ds_rlast = '0; ds_rdata = '0; ds_rid = '0;
    forever begin
      @(negedge clk);
      rst_s = rst;
      r_hs = 1'b0; a_hs = 1'b0; a_cl = 0;
      a_len = ds_arlen; a_id = ds_arid;
      if (pend.size() > 0) r_hs = ds_rvalid[pend[0].client] && ds_rready[pend[0].client];
      for (int i = 0; i < N; i++) begin
        if (ds_arvalid[i] && ds_arready[i]) begin
          a_hs = 1'b1;
          a_cl = i;
        end
      end
      @(posedge clk);
      #2;
      if (rst_s) begin
        pend.delete();
        beat = 0;
      end else begin
        if (r_hs) begin
          if (beat == int'(pend[0].len)) begin
            void'(pend.pop_front());
            beat = 0;
          end else begin
            beat++;
          end
        end
        if (a_hs) begin
          nb.client = a_cl; nb.id = a_id; nb.len = a_len;
          pend.push_back(nb);
        end
      end
      ds_rvalid = '0; ds_rresp = '0; ds_rlast = '0; ds_rdata = '0; ds_rid = '0;
      if (pend.size() > 0 && r_en[pend[0].client]) begin
        c = pend[0].client;
        ds_rvalid[c]          = 1'b1;
        ds_rid[c*IW +: IW]    = pend[0].id;
        ds_rdata[c*DW +: DW]  = beat_data(c, beat);
        ds_rlast[c]           = (beat == int'(pend[0].len));
      end
    end
  end

  // Monitor: compares every upstream R beat and downstream AR handshake to the scoreboard
  initial begin : monitor
    exp_r_t  er;
    exp_ar_t ea;
    forever begin
      @(negedge clk);
      if (!rst) begin
        if (up_rvalid && up_rready) begin
          if (exp_r.size() == 0) begin
            check("r_unexpected_rvalid", up_rvalid, 0);
          end else begin
            er = exp_r.pop_front();
            check("r_resp", up_rresp, er.resp);
            check("r_id", up_rid, er.id);
            check("r_data", up_rdata, er.data);
            check("r_last", up_rlast, er.last);
            r_pops++;
          end
        end
        for (int i = 0; i < N; i++) begin
          if (ds_arvalid[i] && ds_arready[i]) begin
            if (exp_ar.size() == 0) begin
              check("ar_unexpected_arvalid", ds_arvalid[i], 0);
            end else begin
              ea = exp_ar.pop_front();
              check("ar_client", i, ea.client);
              check("ar_addr", ds_araddr, ea.addr);
              check("ar_len", ds_arlen, ea.len);
              check("ar_id", ds_arid, ea.id);
              check("ar_size", ds_arsize, 3'd2);
              check("ar_order", r_pops >= ea.need, 1);
            end
          end
        end
      end
    end
  end

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin : stimulus
    int need;
    rst = 1'b1;
    up_arvalid = 1'b0; up_araddr = '0; up_arlen = '0; up_arsize = '0; up_arburst = '0;
    up_arid = '0; up_arlock = 1'b0; up_arprot = '0; up_rready = 1'b1;
    r_en = '1; ar_en = '1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_arready", up_arready, 0);
    check("rst_rvalid", up_rvalid, 0);
    check("rst_ds_arvalid", ds_arvalid, 0);
    check("rst_ds_rready", ds_rready, 0);
    check("rst_rdata", up_rdata, 0);
    check("rst_rresp_rlast_rid", {up_rresp, up_rlast, up_rid}, 0);
    step();
    rst = 1'b0;
    @(negedge clk);
    check("post_rst_arready", up_arready, 1);
    check("post_rst_rvalid", up_rvalid, 0);

    // Decode and translation: 0x1234 -> client1, local 0x234
    step();
    expect_route(1, 34'h234, 8'd0, 4'd3, 0);
    send_ar(34'h1234, 8'd0, 4'd3);
    drain("decode");

    // Outstanding limit: third AR to client0 waits for one rlast
    step();
    r_en[0] = 1'b0;
    expect_route(0, 34'h100, 8'd0, 4'd1, 0);
    expect_route(0, 34'h100, 8'd0, 4'd2, 0);
    expect_route(0, 34'h100, 8'd0, 4'd3, r_pops + 1);
    send_ar(34'h100, 8'd0, 4'd1);
    send_ar(34'h100, 8'd0, 4'd2);
    send_ar(34'h100, 8'd0, 4'd3);
    repeat (4) @(negedge clk);
    check("limit_held_arvalid", ds_arvalid, 0);
    check("limit_issued_count", exp_ar.size(), 1);
    step();
    r_en[0] = 1'b1;
    drain("limit");

    // Client switch: client1 waits for client0's 4-beat burst to finish
    step();
    r_en[0] = 1'b0;
    expect_route(0, 34'h200, 8'd3, 4'd4, 0);
    need = r_pops + 4;
    expect_route(1, 34'h10, 8'd1, 4'd6, need);
    send_ar(34'h200, 8'd3, 4'd4);
    send_ar(34'h1010, 8'd1, 4'd6);
    repeat (4) @(negedge clk);
    check("switch_held_arvalid", ds_arvalid, 0);
    step();
    r_en[0] = 1'b1;
    drain("switch");

    // DECERR burst with latency and rready stall
    step();
    up_rready = 1'b0;
    expect_decerr(8'd2, 4'd5);
    send_ar(34'h5000, 8'd2, 4'd5);
    @(negedge clk);
    check("decerr_t1_rvalid", up_rvalid, 0);
    @(negedge clk);
    check("decerr_t2_rvalid", up_rvalid, 1);
    check("decerr_t2_rresp", up_rresp, 2'b11);
    check("decerr_no_ds_arvalid", ds_arvalid, 0);
    @(negedge clk);
    check("decerr_stall_rvalid", up_rvalid, 1);
    check("decerr_stall_rlast", up_rlast, 0);
    step();
    up_rready = 1'b1;
    drain("decerr");

    // Simultaneous issue and rlast with one burst in flight
    step();
    r_en[0] = 1'b0;
    expect_route(0, 34'h300, 8'd0, 4'd7, 0);
    send_ar(34'h300, 8'd0, 4'd7);
    step();
    step();
    ar_en[0] = 1'b0;
    expect_route(0, 34'h304, 8'd0, 4'd8, 0);
    send_ar(34'h304, 8'd0, 4'd8);
    @(negedge clk);
    check("simul_pending_arvalid", ds_arvalid, 2'b01);
    step();
    ar_en[0] = 1'b1;
    r_en[0] = 1'b1;
    expect_route(1, 34'h300, 8'd0, 4'd9, 0);
    send_ar(34'h1300, 8'd0, 4'd9);
    drain("simultaneous");

    // Reset in the middle of a DECERR burst, then route normally
    step();
    up_rready = 1'b0;
    send_ar(34'h6000, 8'd3, 4'd2);
    repeat (2) @(negedge clk);
    check("midrst_decerr_rvalid", up_rvalid, 1);
    step();
    rst = 1'b1;
    @(negedge clk);
    check("midrst_during_rvalid", up_rvalid, 0);
    check("midrst_during_arready", up_arready, 0);
    step();
    rst = 1'b0;
    up_rready = 1'b1;
    @(negedge clk);
    check("midrst_after_rvalid", up_rvalid, 0);
    check("midrst_after_arready", up_arready, 1);
    step();
    expect_route(0, 34'h40, 8'd1, 4'd1, 0);
    send_ar(34'h40, 8'd1, 4'd1);
    drain("after_reset");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
